// File: rtl/retire_trace_buf.sv
// Retirement-trace buffer: classifies each commit event, tags it with a sequence number and queues it for a trace sink.
// Latency: 1 cycle from a commit into an empty queue to trace_valid; head fields come straight from storage.
// Backpressure: head holds while trace_ready=0; a push into a full queue with no pop is dropped and counted. Option: TRACE_FILTER_NOP_EN.
module retire_trace_buf #(
    parameter int DEPTH  = 8,
    parameter int XLEN   = 32,
    parameter int INUM_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       trace_en,
    input  logic                       retire_valid,
    input  logic [XLEN-1:0]            retire_pc,
    input  logic                       reg_write,
    input  logic [4:0]                 rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       mem_read,
    input  logic                       mem_write,
    input  logic [XLEN-1:0]            mem_addr,
    input  logic [XLEN-1:0]            mem_data,
    input  logic                       trace_ready,
    output logic                       trace_valid,
    output logic [2:0]                 trace_kind,
    output logic [INUM_W-1:0]          trace_inum,
    output logic [XLEN-1:0]            trace_pc,
    output logic [XLEN-1:0]            trace_wdata,
    output logic [XLEN-1:0]            trace_addr,
    output logic [XLEN-1:0]            trace_mdata,
    output logic [4:0]                 trace_rd,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       stall_req,
    output logic [15:0]                drop_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [2:0] K_NOP   = 3'd0;
    localparam logic [2:0] K_REG   = 3'd1;
    localparam logic [2:0] K_LOAD  = 3'd2;
    localparam logic [2:0] K_STORE = 3'd3;
    localparam logic [2:0] K_STU   = 3'd4;

    typedef struct packed {
        logic [2:0]        kind;
        logic [INUM_W-1:0] inum;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   wdata;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   mdata;
        logic [4:0]        rd;
    } trace_ent_t;

    logic [INUM_W-1:0] inum;
    logic [CW-1:0]     wptr, rptr;
    trace_ent_t        mem [DEPTH];
    trace_ent_t        new_ent, head_ent, out_ent;
    logic [2:0]        kind;
    logic              evt_vld, push, pop, full, do_push, drop;

    assign evt_vld = retire_valid & trace_en;

    always_comb begin
        kind = K_NOP;
        if (reg_write && mem_write)     kind = K_STU;
        else if (reg_write && mem_read) kind = K_LOAD;
        else if (mem_write)             kind = K_STORE;
        else if (reg_write)             kind = K_REG;
    end

    // Fields that mean nothing for the kind are stored as zero so the sink sees a canonical record.
    always_comb begin
        new_ent      = '0;
        new_ent.kind = kind;
        new_ent.inum = inum;
        new_ent.pc   = retire_pc;
        if (kind == K_REG || kind == K_LOAD || kind == K_STU) begin
            new_ent.rd    = rd;
            new_ent.wdata = wb_data;
        end
        if (kind == K_LOAD || kind == K_STORE || kind == K_STU)
            new_ent.addr = mem_addr;
        if (kind == K_STORE || kind == K_STU)
            new_ent.mdata = mem_data;
    end

`ifdef TRACE_FILTER_NOP_EN
    assign push = evt_vld & (kind != K_NOP);
`else
    assign push = evt_vld;
`endif

    assign count       = wptr - rptr;
    assign trace_valid = (wptr != rptr);
    assign full        = (count == CW'(DEPTH));
    assign stall_req   = (count >= CW'(DEPTH - 1));
    assign pop         = trace_valid & trace_ready;
    assign do_push     = push & (~full | pop);
    assign drop        = push & full & ~pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            inum       <= '0;
            drop_count <= '0;
        end else begin
            if (do_push) wptr <= wptr + CW'(1);
            if (pop)     rptr <= rptr + CW'(1);
            // Every qualified event consumes a number, so gaps in the trace reveal drops or filtering.
            if (evt_vld) inum <= inum + INUM_W'(1);
            if (drop && drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= new_ent;
    end

    assign head_ent = mem[rptr[AW-1:0]];
    assign out_ent  = trace_valid ? head_ent : '0;

    assign trace_kind  = out_ent.kind;
    assign trace_inum  = out_ent.inum;
    assign trace_pc    = out_ent.pc;
    assign trace_wdata = out_ent.wdata;
    assign trace_addr  = out_ent.addr;
    assign trace_mdata = out_ent.mdata;
    assign trace_rd    = out_ent.rd;
endmodule

// File: tb/tb_retire_trace_buf.sv
// Bench for retire_trace_buf: directed scenarios plus randomized traffic against a queue-level reference model.
module tb_retire_trace_buf;
    localparam int DEPTH = 8;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        trace_en = 0, retire_valid = 0, reg_write = 0, mem_read = 0, mem_write = 0, trace_ready = 0;
    logic [31:0] retire_pc = 0, wb_data = 0, mem_addr = 0, mem_data = 0;
    logic [4:0]  rd = 0;
    logic        trace_valid, stall_req;
    logic [2:0]  trace_kind;
    logic [31:0] trace_inum, trace_pc, trace_wdata, trace_addr, trace_mdata;
    logic [4:0]  trace_rd;
    logic [3:0]  count;
    logic [15:0] drop_count;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] inum, pc, wdata, addr, mdata;
        logic [4:0]  rd;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_inum;
    int          m_drop;

    retire_trace_buf #(.DEPTH(DEPTH), .XLEN(32), .INUM_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .trace_en(trace_en), .retire_valid(retire_valid),
        .retire_pc(retire_pc), .reg_write(reg_write), .rd(rd), .wb_data(wb_data),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_data(mem_data),
        .trace_ready(trace_ready), .trace_valid(trace_valid), .trace_kind(trace_kind),
        .trace_inum(trace_inum), .trace_pc(trace_pc), .trace_wdata(trace_wdata),
        .trace_addr(trace_addr), .trace_mdata(trace_mdata), .trace_rd(trace_rd),
        .count(count), .stall_req(stall_req), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    // One clock: the model consumes the inputs the DUT sees at this edge, then outputs are sampled 1ns later.
    task automatic tick();
        ent_t e;
        bit   evt, pop, push;
        evt = retire_valid && trace_en;
        pop = (mq.size() != 0) && trace_ready;
        e = '{kind: 3'd0, inum: m_inum, pc: retire_pc, wdata: 0, addr: 0, mdata: 0, rd: 0};
        if (reg_write && mem_write)     e.kind = 3'd4;
        else if (reg_write && mem_read) e.kind = 3'd2;
        else if (mem_write)             e.kind = 3'd3;
        else if (reg_write)             e.kind = 3'd1;
        if (e.kind inside {3'd1, 3'd2, 3'd4}) begin e.rd = rd; e.wdata = wb_data; end
        if (e.kind inside {3'd2, 3'd3, 3'd4}) e.addr = mem_addr;
        if (e.kind inside {3'd3, 3'd4}) e.mdata = mem_data;
        push = evt;
`ifdef TRACE_FILTER_NOP_EN
        if (e.kind == 3'd0) push = 0;
`endif
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(e);
            else if (m_drop < 16'hFFFF) m_drop++;
        end
        if (evt) m_inum++;
        #1;
    endtask

    task automatic set_ev(input bit v, input logic [31:0] pc, input bit rw, input bit mr, input bit mw,
                          input logic [4:0] r, input logic [31:0] wd, input logic [31:0] ma, input logic [31:0] md);
        retire_valid = v; trace_en = 1; retire_pc = pc; reg_write = rw; mem_read = mr; mem_write = mw;
        rd = r; wb_data = wd; mem_addr = ma; mem_data = md;
    endtask

    task automatic idle();
        set_ev(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        idle(); trace_ready = 0; rst_n = 0;
        mq.delete(); m_inum = 0; m_drop = 0;
        #10 rst_n = 1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", trace_valid); end
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (stall_req !== 1'b0 || drop_count !== 16'd0) begin errors++; $display("FAIL reset_stall_drop got %0b/%0d exp 0/0", stall_req, drop_count); end
        checks++; if ({trace_kind, trace_inum, trace_pc, trace_wdata, trace_addr, trace_mdata, trace_rd} !== '0) begin errors++; $display("FAIL reset_fields got kind %0d inum %0h pc %0h exp all 0", trace_kind, trace_inum, trace_pc); end
    endtask

    task automatic test_single_reg();
        do_reset();
        trace_ready = 1;
        set_ev(1, 32'h10, 1, 0, 0, 5'd5, 32'h1234, 32'hDEAD, 32'hBEEF);
        tick(); idle();
        checks++; if (trace_valid !== 1'b1 || count !== 4'd1) begin errors++; $display("FAIL reg_valid got %0b cnt %0d exp 1 cnt 1", trace_valid, count); end
        checks++; if (trace_kind !== 3'd1 || trace_inum !== 32'd0 || trace_pc !== 32'h10) begin errors++; $display("FAIL reg_head got kind %0d inum %0d pc %0h exp 1 0 10", trace_kind, trace_inum, trace_pc); end
        checks++; if (trace_rd !== 5'd5 || trace_wdata !== 32'h1234 || trace_addr !== 32'h0 || trace_mdata !== 32'h0) begin errors++; $display("FAIL reg_fields got rd %0d wd %0h ad %0h md %0h exp 5 1234 0 0", trace_rd, trace_wdata, trace_addr, trace_mdata); end
        tick();
        checks++; if (trace_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL reg_drain got valid %0b cnt %0d exp 0 0", trace_valid, count); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  ek [4] = '{3'd2, 3'd3, 3'd4, 3'd0};
        logic [4:0]  erd[4] = '{5'd7, 5'd0, 5'd9, 5'd0};
        logic [31:0] ewd[4] = '{32'hAA, 32'h0, 32'h99, 32'h0};
        logic [31:0] ead[4] = '{32'h100, 32'h104, 32'h108, 32'h0};
        logic [31:0] emd[4] = '{32'h0, 32'hBEEF, 32'hCAFE, 32'h0};
        do_reset();
        trace_ready = 1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: set_ev(1, 32'h200, 1, 1, 0, 5'd7, 32'hAA, 32'h100, 32'h55);
                1: set_ev(1, 32'h204, 0, 0, 1, 5'd3, 32'h77, 32'h104, 32'hBEEF);
                2: set_ev(1, 32'h208, 1, 1, 1, 5'd9, 32'h99, 32'h108, 32'hCAFE);
                default: set_ev(1, 32'h20C, 0, 1, 0, 5'd4, 32'h44, 32'h300, 32'h66);
            endcase
            tick();
`ifdef TRACE_FILTER_NOP_EN
            if (i == 3) begin
                checks++; if (trace_valid !== 1'b0) begin errors++; $display("FAIL b2b_nop_filtered got valid %0b exp 0", trace_valid); end
                continue;
            end
`endif
            checks++;
            if (trace_valid !== 1'b1 || trace_kind !== ek[i] || trace_inum !== 32'(i) || trace_pc !== 32'h200 + 32'(4*i))
                begin errors++; $display("FAIL b2b_head%0d got v %0b kind %0d inum %0d pc %0h exp 1 %0d %0d %0h", i, trace_valid, trace_kind, trace_inum, trace_pc, ek[i], i, 32'h200 + 4*i); end
            checks++;
            if (trace_rd !== erd[i] || trace_wdata !== ewd[i] || trace_addr !== ead[i] || trace_mdata !== emd[i])
                begin errors++; $display("FAIL b2b_fields%0d got rd %0d wd %0h ad %0h md %0h exp %0d %0h %0h %0h", i, trace_rd, trace_wdata, trace_addr, trace_mdata, erd[i], ewd[i], ead[i], emd[i]); end
        end
        idle();
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_ev(1, 32'h400 + 32'(4*i), 1, 0, 0, 5'(i), 32'(i), 0, 0);
            tick();
            checks++;
            if (count !== 4'((i < 8) ? i + 1 : 8) || stall_req !== (i >= 6))
                begin errors++; $display("FAIL ovf_fill%0d got cnt %0d stall %0b exp %0d %0b", i, count, stall_req, (i < 8) ? i + 1 : 8, i >= 6); end
        end
        idle();
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL ovf_drops got %0d exp 2", drop_count); end
        trace_ready = 1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (trace_valid !== 1'b1 || trace_inum !== 32'(i)) begin errors++; $display("FAIL ovf_drain%0d got v %0b inum %0d exp 1 %0d", i, trace_valid, trace_inum, i); end
            tick();
        end
        checks++; if (trace_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL ovf_empty got v %0b cnt %0d exp 0 0", trace_valid, count); end
        set_ev(1, 32'h500, 1, 0, 0, 5'd1, 32'h1, 0, 0);
        tick(); idle();
        checks++; if (trace_inum !== 32'd10) begin errors++; $display("FAIL ovf_next_inum got %0d exp 10", trace_inum); end
    endtask

    task automatic test_full_push_pop();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_ev(1, 32'h1000 + 32'(4*i), 1, 0, 0, 5'd2, 32'(i), 0, 0);
            tick();
        end
        trace_ready = 1;
        set_ev(1, 32'hABC0, 1, 0, 0, 5'd3, 32'h77, 0, 0);
        tick(); idle();
        checks++; if (count !== 4'd8 || drop_count !== 16'd0) begin errors++; $display("FAIL full_pp got cnt %0d drops %0d exp 8 0", count, drop_count); end
        checks++; if (trace_inum !== 32'd1) begin errors++; $display("FAIL full_pp_head got inum %0d exp 1", trace_inum); end
        for (int i = 0; i < 7; i++) tick();
        checks++; if (trace_inum !== 32'd8 || trace_pc !== 32'hABC0 || trace_wdata !== 32'h77) begin errors++; $display("FAIL full_pp_tail got inum %0d pc %0h wd %0h exp 8 abc0 77", trace_inum, trace_pc, trace_wdata); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_ev(1, 32'h60 + 32'(4*i), 1, 0, 0, 5'd1, 32'(i), 0, 0);
            tick();
        end
        idle();
        checks++; if (count !== 4'd3) begin errors++; $display("FAIL mrst_pre got cnt %0d exp 3", count); end
        #2 rst_n = 0;
        mq.delete(); m_inum = 0; m_drop = 0;
        #1;
        checks++; if (trace_valid !== 1'b0 || count !== 4'd0) begin errors++; $display("FAIL mrst_async got v %0b cnt %0d exp 0 0", trace_valid, count); end
        #1 rst_n = 1;
        set_ev(1, 32'h80, 1, 0, 0, 5'd6, 32'h6, 0, 0);
        tick(); idle();
        checks++; if (trace_valid !== 1'b1 || trace_inum !== 32'd0) begin errors++; $display("FAIL mrst_inum got v %0b inum %0d exp 1 0", trace_valid, trace_inum); end
    endtask

    task automatic test_filter();
`ifdef TRACE_FILTER_NOP_EN
        int exp_inum[$] = '{1, 3};
`else
        int exp_inum[$] = '{0, 1, 2, 3};
`endif
        do_reset();
        for (int i = 0; i < 4; i++) begin
            set_ev(1, 32'h900 + 32'(4*i), i[0], 0, 0, 5'd8, 32'h5, 0, 0);
            tick();
        end
        idle();
        checks++; if (count !== 4'(exp_inum.size())) begin errors++; $display("FAIL filt_count got %0d exp %0d", count, exp_inum.size()); end
        trace_ready = 1;
        foreach (exp_inum[k]) begin
            checks++; if (trace_valid !== 1'b1 || trace_inum !== 32'(exp_inum[k])) begin errors++; $display("FAIL filt_inum%0d got v %0b inum %0d exp 1 %0d", k, trace_valid, trace_inum, exp_inum[k]); end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            set_ev($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 1), 5'($urandom), $urandom, $urandom, $urandom);
            trace_en = ($urandom_range(0, 9) != 0);
            trace_ready = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (trace_valid !== (mq.size() != 0) || count !== 4'(mq.size()) || drop_count !== 16'(m_drop) || stall_req !== (mq.size() >= DEPTH - 1))
                begin errors++; $display("FAIL rnd_state%0d got v %0b cnt %0d drop %0d stall %0b exp cnt %0d drop %0d", c, trace_valid, count, drop_count, stall_req, mq.size(), m_drop); end
            if (mq.size() != 0) begin
                checks++;
                if (trace_kind !== mq[0].kind || trace_inum !== mq[0].inum || trace_pc !== mq[0].pc || trace_rd !== mq[0].rd ||
                    trace_wdata !== mq[0].wdata || trace_addr !== mq[0].addr || trace_mdata !== mq[0].mdata)
                    begin errors++; $display("FAIL rnd_head%0d got kind %0d inum %0d pc %0h exp kind %0d inum %0d pc %0h", c, trace_kind, trace_inum, trace_pc, mq[0].kind, mq[0].inum, mq[0].pc); end
            end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_reg();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_mid_reset();
        test_filter();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
